booth_r4_seq_mult: RTL and testbench

//  Parametrised sequential radix-4 Booth multiplier with start/done handshake and signed/unsigned mode.

---
 rtl/booth_pkg.sv | 29 ++
 rtl/booth_r4_recoder.sv | 21 ++
 rtl/booth_r4_seq_mult.sv | 131 +++++++++++++
 tb/tb_booth_r4_seq_mult.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the radix-4 Booth multiplier family.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } booth_state_t;

    typedef enum logic [2:0] {
        D_ZERO,
        D_PA,
        D_P2A,
        D_M2A,
        D_MA
    } booth_digit_t;

    // Extended operand width: even and at least WIDTH+1, so an unsigned operand
    // always carries a zero sign bit and the recoding consumes it in whole pairs.
    function automatic int xw_of(input int width);
        return 2 * ((width + 2) / 2);
    endfunction

    // Step counter width, never narrower than one bit.
    function automatic int cnt_w_of(input int nstep);
        return (nstep > 1) ? $clog2(nstep) : 1;
    endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window to a signed digit.
module booth_r4_recoder
    import booth_pkg::*;
(
    input  logic [2:0]   window,
    output booth_digit_t digit
);

    // Pure table lookup; 000 and 111 both mean "no contribution".
    always_comb begin
        digit = D_ZERO;
        case (window)
            3'b001, 3'b010: digit = D_PA;
            3'b011:         digit = D_P2A;
            3'b100:         digit = D_M2A;
            3'b101, 3'b110: digit = D_MA;
            default:        digit = D_ZERO;
        endcase
    end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier retiring two multiplier bits per cycle,
// with a start/done handshake and signed or unsigned operand interpretation.
module booth_r4_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int XW    = xw_of(WIDTH);
    localparam int NSTEP = XW / 2;
    localparam int CW    = cnt_w_of(NSTEP);
    localparam int AW    = XW + 2;
    localparam int PW    = AW + XW + 1;
    localparam int EXT_A = AW - WIDTH;
    localparam int EXT_B = XW - WIDTH;
    localparam logic [CW-1:0] LAST_CNT = CW'(NSTEP - 1);

    booth_state_t       state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [AW-1:0]      a_q, a_d;
    logic [AW-1:0]      nega_q, nega_d;
    logic [PW-1:0]      p_q, p_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    booth_digit_t       digit;
    logic               accept;
    logic               last_step;
    logic [AW-1:0]      a_ext;
    logic [XW-1:0]      b_ext;
    logic [AW-1:0]      addend;
    logic [AW-1:0]      sum;
    logic [PW-1:0]      shifted;

    booth_r4_recoder u_recoder (
        .window (p_q[2:0]),
        .digit  (digit)
    );

    assign accept    = start && ready;
    assign last_step = (cnt_q == LAST_CNT);
    assign product   = product_q;

    // State and datapath registers; a synchronous reset aborts any multiply in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            nega_q    <= '0;
            p_q       <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            nega_q    <= nega_d;
            p_q       <= p_d;
            product_q <= product_d;
        end
    end

    // Next state: DONE can go straight back to CALC when a new start is waiting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (last_step) state_d = DONE;
            DONE:    state_d = start ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state alone.
    always_comb begin
        ready = (state_q == IDLE) || (state_q == DONE);
        busy  = (state_q == CALC);
        done  = (state_q == DONE);
    end

    // One Booth step: add the recoded digit into the upper field, then shift right by two
    // keeping the sign; operands are captured on accept and the product only on the final step.
    always_comb begin
        a_d       = a_q;
        nega_d    = nega_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        a_ext = signed_mode ? {{EXT_A{multiplicand[WIDTH-1]}}, multiplicand}
                            : {{EXT_A{1'b0}}, multiplicand};
        b_ext = signed_mode ? {{EXT_B{multiplier[WIDTH-1]}}, multiplier}
                            : {{EXT_B{1'b0}}, multiplier};

        addend = '0;
        case (digit)
            D_PA:    addend = a_q;
            D_P2A:   addend = {a_q[AW-2:0], 1'b0};
            D_M2A:   addend = {nega_q[AW-2:0], 1'b0};
            D_MA:    addend = nega_q;
            default: addend = '0;
        endcase

        sum     = p_q[PW-1:XW+1] + addend;
        shifted = $signed({sum, p_q[XW:0]}) >>> 2;

        if (accept) begin
            a_d    = a_ext;
            nega_d = ~a_ext + AW'(1);
            p_d    = {{AW{1'b0}}, b_ext, 1'b0};
            cnt_d  = '0;
        end else if (state_q == CALC) begin
            p_d   = shifted;
            cnt_d = cnt_q + CW'(1);
            if (last_step) begin
                product_d = shifted[2*WIDTH:1];
            end
        end
    end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Directed and randomised checks of the Booth multiplier at WIDTH=8 and WIDTH=6.
module tb_booth_r4_seq_mult;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8, start8, sm8;
    logic [7:0]  a8, b8;
    logic        ready8, busy8, done8;
    logic [15:0] product8;

    logic        rst6, start6, sm6;
    logic [5:0]  a6, b6;
    logic        ready6, busy6, done6;
    logic [11:0] product6;

    int checks = 0;
    int fails  = 0;

    booth_r4_seq_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .signed_mode(sm8),
        .multiplicand(a8), .multiplier(b8),
        .ready(ready8), .busy(busy8), .done(done8), .product(product8)
    );

    booth_r4_seq_mult #(.WIDTH(6)) dut6 (
        .clk(clk), .rst(rst6), .start(start6), .signed_mode(sm6),
        .multiplicand(a6), .multiplier(b6),
        .ready(ready6), .busy(busy6), .done(done6), .product(product6)
    );

    // Drives one multiply on the 8-bit DUT from a negedge; returns at the negedge where done is seen.
    task automatic apply_stimulus8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                                   output logic [15:0] prod, output int lat);
        sm8 = sm; a8 = a; b8 = b; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!done8) lat = -1;
        prod = product8;
    endtask

    // Same driver for the 6-bit DUT.
    task automatic apply_stimulus6(input logic sm, input logic [5:0] a, input logic [5:0] b,
                                   output logic [11:0] prod, output int lat);
        sm6 = sm; a6 = a; b6 = b; start6 = 1'b1;
        @(negedge clk);
        start6 = 1'b0;
        lat = 1;
        while (!done6 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!done6) lat = -1;
        prod = product6;
    endtask

    task automatic test_reset();
        rst8 = 1'b1; rst6 = 1'b1;
        start8 = 1'b0; start6 = 1'b0;
        sm8 = 1'b0; sm6 = 1'b0; a8 = '0; b8 = '0; a6 = '0; b6 = '0;
        repeat (3) @(negedge clk);
        rst8 = 1'b0; rst6 = 1'b0;
        checks++;
        if ({ready8, busy8, done8} !== 3'b100) begin
            fails++; $display("[TB] FAIL reset_flags8: got %b expected 100", {ready8, busy8, done8});
        end
        checks++;
        if (product8 !== 16'h0000) begin
            fails++; $display("[TB] FAIL reset_product8: got %h expected 0000", product8);
        end
        checks++;
        if ({ready6, busy6, done6, product6} !== {3'b100, 12'h000}) begin
            fails++; $display("[TB] FAIL reset_dut6: got %b/%h expected 100/000", {ready6, busy6, done6}, product6);
        end
    endtask

    task automatic test_signed_basic();
        int lat;
        int bad_flags;
        sm8 = 1'b1; a8 = 8'hFD; b8 = 8'h05; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 1;
        bad_flags = 0;
        while (!done8 && lat < 20) begin
            if (ready8 !== 1'b0 || busy8 !== 1'b1) bad_flags++;
            @(negedge clk);
            lat++;
        end
        checks++;
        if (bad_flags != 0) begin
            fails++; $display("[TB] FAIL calc_flags: got %0d bad cycles expected 0", bad_flags);
        end
        checks++;
        if (lat != 6) begin
            fails++; $display("[TB] FAIL latency_m3x5: got %0d expected 6", lat);
        end
        checks++;
        if (product8 !== 16'hFFF1) begin
            fails++; $display("[TB] FAIL m3x5: got %h expected fff1", product8);
        end
        @(negedge clk);
        checks++;
        if (done8 !== 1'b0) begin
            fails++; $display("[TB] FAIL done_pulse_width: got %b expected 0", done8);
        end
    endtask

    task automatic test_extremes();
        logic [15:0] p;
        int lat;
        apply_stimulus8(1'b1, 8'h80, 8'h80, p, lat);
        checks++;
        if (p !== 16'h4000 || lat != 6) begin
            fails++; $display("[TB] FAIL s_m128xm128: got %h lat %0d expected 4000 lat 6", p, lat);
        end
        apply_stimulus8(1'b0, 8'hFF, 8'hFF, p, lat);
        checks++;
        if (p !== 16'hFE01 || lat != 6) begin
            fails++; $display("[TB] FAIL u_255x255: got %h lat %0d expected fe01 lat 6", p, lat);
        end
        apply_stimulus8(1'b0, 8'hFF, 8'h00, p, lat);
        checks++;
        if (p !== 16'h0000 || lat != 6) begin
            fails++; $display("[TB] FAIL u_255x0: got %h lat %0d expected 0000 lat 6", p, lat);
        end
        apply_stimulus8(1'b1, 8'h7F, 8'h80, p, lat);
        checks++;
        if (p !== 16'hC080) begin
            fails++; $display("[TB] FAIL s_127xm128: got %h expected c080", p);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [15:0] p;
        int lat;
        int unstable;
        apply_stimulus8(1'b1, 8'd7, 8'd9, p, lat);
        checks++;
        if (p !== 16'h003F) begin
            fails++; $display("[TB] FAIL b2b_first: got %h expected 003f", p);
        end
        sm8 = 1'b1; a8 = 8'd12; b8 = 8'hFE; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1) begin
            fails++; $display("[TB] FAIL b2b_accept: got busy %b expected 1", busy8);
        end
        lat = 1;
        unstable = 0;
        while (!done8 && lat < 20) begin
            if (product8 !== 16'h003F) unstable++;
            @(negedge clk);
            lat++;
        end
        checks++;
        if (unstable != 0) begin
            fails++; $display("[TB] FAIL b2b_hold: got %0d changed cycles expected 0", unstable);
        end
        checks++;
        if (lat != 6 || product8 !== 16'hFFE8) begin
            fails++; $display("[TB] FAIL b2b_second: got %h lat %0d expected ffe8 lat 6", product8, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int dones;
        int done_at;
        sm8 = 1'b1; a8 = 8'd10; b8 = 8'hF9; start8 = 1'b1;
        dones = 0;
        done_at = -1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (done8) begin
                dones++;
                done_at = c;
            end
            if (c == 1) start8 = 1'b0;
            if (c == 2) begin
                sm8 = 1'b0; a8 = 8'd3; b8 = 8'd3; start8 = 1'b1;
            end
            if (c == 3) start8 = 1'b0;
        end
        checks++;
        if (dones != 1 || done_at != 6) begin
            fails++; $display("[TB] FAIL busy_ignore_done: got %0d pulses at %0d expected 1 at 6", dones, done_at);
        end
        checks++;
        if (product8 !== 16'hFFBA) begin
            fails++; $display("[TB] FAIL busy_ignore_product: got %h expected ffba", product8);
        end
    endtask

    task automatic test_reset_mid_calc();
        int dones;
        sm8 = 1'b1; a8 = 8'd100; b8 = 8'd100; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        checks++;
        if ({ready8, busy8, done8} !== 3'b100 || product8 !== 16'h0000) begin
            fails++; $display("[TB] FAIL abort_state: got %b/%h expected 100/0000", {ready8, busy8, done8}, product8);
        end
        dones = 0;
        repeat (10) begin
            @(negedge clk);
            if (done8) dones++;
        end
        checks++;
        if (dones != 0 || product8 !== 16'h0000) begin
            fails++; $display("[TB] FAIL abort_no_done: got %0d pulses product %h expected 0/0000", dones, product8);
        end
    endtask

    task automatic test_width6();
        logic [11:0] p;
        logic [11:0] expected;
        logic        sm;
        logic [5:0]  a, b;
        int lat;
        int ia, ib;
        apply_stimulus6(1'b1, 6'h20, 6'h1F, p, lat);
        checks++;
        if (p !== 12'hC20 || lat != 5) begin
            fails++; $display("[TB] FAIL w6_m32x31: got %h lat %0d expected c20 lat 5", p, lat);
        end
        for (int i = 0; i < 2000; i++) begin
            sm = 1'($urandom_range(0, 1));
            a  = 6'($urandom);
            b  = 6'($urandom);
            ia = sm ? int'($signed(a)) : int'(a);
            ib = sm ? int'($signed(b)) : int'(b);
            expected = 12'(ia * ib);
            apply_stimulus6(sm, a, b, p, lat);
            checks++;
            if (p !== expected || lat != 5) begin
                fails++;
                $display("[TB] FAIL w6_random sm=%b a=%h b=%h: got %h lat %0d expected %h lat 5",
                         sm, a, b, p, lat, expected);
            end
        end
    endtask

    initial begin
        test_reset();
        test_signed_basic();
        test_extremes();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid_calc();
        test_width6();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
